pdp8l_tty_buffered: RTL and testbench

//  PDP-8/L console/serial TTY interface with FIFO-buffered keyboard and printer paths.

---
 rtl/pdp8l_tty_pkg.sv | 27 ++
 rtl/pdp8l_tty_fifo_buf.sv | 57 +++++
 rtl/pdp8l_tty_buffered.sv | 176 +++++++++++++++++
 tb/tb_pdp8l_tty_buffered.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8l_tty_pkg.sv
// Shared definitions for the buffered PDP-8/L TTY interface:
// ARM register indices, IOT function codes and the IOP pulse qualifier.
package pdp8l_tty_pkg;

  localparam logic [1:0] R_ID  = 2'd0;
  localparam logic [1:0] R_KB  = 2'd1;
  localparam logic [1:0] R_PR  = 2'd2;
  localparam logic [1:0] R_CTL = 2'd3;

  localparam logic [15:0] ID_MAGIC = 16'h5454;
  localparam logic [3:0]  ID_TYPE  = 4'h1;

  typedef enum logic [2:0] {
    F_SKIP  = 3'd1,
    F_CLR   = 3'd2,
    F_RD    = 3'd4,
    F_IE    = 3'd5,
    F_RDCLR = 3'd6
  } iot_fn_e;

  // An IOT is live while the IO pulse selected by its low function bits is high.
  function automatic logic iop_pulse(input logic biop1, input logic biop2,
                                     input logic biop4, input logic [2:0] fn);
    return (biop1 & fn[0]) | (biop2 & (fn[1:0] == 2'd2)) | (biop4 & (fn == 3'd4));
  endfunction

endpackage

// File: rtl/pdp8l_tty_fifo_buf.sv
// Synchronous FIFO used for the keyboard and printer character paths.
// Registered count; head is valid combinationally and reads 0 when empty.
// Push while full is accepted only if a pop happens in the same cycle.
module pdp8l_tty_fifo_buf #(
  parameter int LOG2 = 4,
  parameter int W    = 8
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [LOG2:0] count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << LOG2;
  localparam logic [LOG2-1:0] PTR_ONE = 1;
  localparam logic [LOG2:0]   CNT_ONE = 1;

  logic [W-1:0]    mem [DEPTH];
  logic [LOG2-1:0] rd_ptr;
  logic [LOG2-1:0] wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = count[LOG2];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Character storage; contents need no reset.
  always_ff @(posedge CLOCK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pdp8l_tty_buffered.sv
// PDP-8/L console TTY with FIFO-buffered keyboard and printer paths.
// The ARM fills the keyboard FIFO and drains the printer FIFO through four
// registers; the PDP sees the usual KSF/KCC/KRS/KIE/KRB and TSF/TCF/TPC/TSK/TLS.
// Optional build macro PDP8L_TTY_LOOPBACK_EN adds printer->keyboard loopback
// controlled by R3 bit 2.
module pdp8l_tty_buffered
  import pdp8l_tty_pkg::*;
#(
  parameter logic [5:0]  KBDEV   = 6'o03,
  parameter logic [5:0]  PRDEV   = 6'o04,
  parameter int          KBLOG2  = 4,
  parameter int          PRLOG2  = 4,
  parameter logic [11:0] VERSION = 12'h002
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwpulse,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  output logic [11:0] INPUTBUS,
  output logic        AC_CLEAR,
  output logic        INT_RQST,
  output logic        IO_SKIP,
  input  logic [11:0] BAC,
  input  logic        BIOP1,
  input  logic        BIOP2,
  input  logic        BIOP4,
  input  logic [11:0] BMB,
  input  logic        BUSINIT
);

  logic rst;
  logic intenab, kbflag, prflag, prpend, kbovf, lpbk;
  logic lastiop, iop_kb, iop_pr, iop_any, iop_act;
  logic arm_kb_wr, arm_pr_pop, arm_ctl_wr, lb_move;
  logic [2:0] fn;

  logic              kb_push, kb_pop, kb_full, kb_empty;
  logic [7:0]        kb_wdata, kb_head;
  logic [KBLOG2:0]   kb_count;
  logic              pr_push, pr_pop, pr_full, pr_empty;
  logic [7:0]        pr_head;
  logic [PRLOG2:0]   pr_count;

  logic unused_bits;
  assign unused_bits = ^{BMB[11:9], BAC[11:8], armwdata[30:8]};

  assign rst = RESET | BUSINIT;
  assign fn  = BMB[2:0];

  assign iop_kb  = iop_pulse(BIOP1, BIOP2, BIOP4, fn) && (BMB[8:3] == KBDEV);
  assign iop_pr  = iop_pulse(BIOP1, BIOP2, BIOP4, fn) && (BMB[8:3] == PRDEV);
  assign iop_any = iop_kb | iop_pr;
  // An ARM write on the rising edge swallows that IOT entirely.
  assign iop_act = iop_any & ~lastiop & ~armwpulse;

  assign arm_kb_wr  = armwpulse & (armwaddr == R_KB);
  assign arm_pr_pop = armwpulse & (armwaddr == R_PR) & armwdata[31];
  assign arm_ctl_wr = armwpulse & (armwaddr == R_CTL);

`ifdef PDP8L_TTY_LOOPBACK_EN
  // Loopback yields to ARM traffic on either FIFO port it would share.
  assign lb_move = lpbk & ~arm_pr_pop & ~arm_kb_wr & ~pr_empty & ~kb_full;
`else
  assign lb_move = 1'b0;
  assign lpbk    = 1'b0;
`endif

  assign kb_push  = arm_kb_wr | lb_move;
  assign kb_wdata = arm_kb_wr ? armwdata[7:0] : pr_head;
  assign kb_pop   = iop_act & iop_kb & ((fn == F_CLR) | (fn == F_RDCLR));
  assign pr_push  = iop_act & iop_pr & ((fn == F_RD) | (fn == F_RDCLR));
  assign pr_pop   = arm_pr_pop | lb_move;

  assign INT_RQST = intenab & (kbflag | prflag);

  pdp8l_tty_fifo_buf #(.LOG2(KBLOG2), .W(8)) u_kb_fifo (
    .CLOCK(CLOCK), .RESET(rst), .push(kb_push), .wdata(kb_wdata), .pop(kb_pop),
    .head(kb_head), .count(kb_count), .full(kb_full), .empty(kb_empty)
  );

  pdp8l_tty_fifo_buf #(.LOG2(PRLOG2), .W(8)) u_pr_fifo (
    .CLOCK(CLOCK), .RESET(rst), .push(pr_push), .wdata(BAC[7:0]), .pop(pr_pop),
    .head(pr_head), .count(pr_count), .full(pr_full), .empty(pr_empty)
  );

  // IOP edge detector.
  always_ff @(posedge CLOCK) begin
    if (rst) lastiop <= 1'b0;
    else     lastiop <= iop_any;
  end

  // Device flags, interrupt enable and ARM control bits.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      intenab <= 1'b0;
      kbflag  <= 1'b0;
      prflag  <= 1'b0;
      prpend  <= 1'b0;
      kbovf   <= 1'b0;
`ifdef PDP8L_TTY_LOOPBACK_EN
      lpbk    <= 1'b0;
`endif
    end else begin
      if (arm_kb_wr & kb_full) kbovf <= 1'b1;
      if (arm_ctl_wr) begin
        if (armwdata[0]) kbovf  <= 1'b0;
        if (armwdata[1]) prflag <= 1'b1;
`ifdef PDP8L_TTY_LOOPBACK_EN
        lpbk <= armwdata[2];
`endif
      end
      if (iop_act & iop_kb) begin
        case (fn)
          F_CLR, F_RDCLR: kbflag  <= 1'b0;
          F_IE:           intenab <= BAC[0];
          default: ;
        endcase
      end
      if (iop_act & iop_pr) begin
        case (fn)
          F_CLR:   prflag <= 1'b0;
          F_RD:    prpend <= 1'b1;
          F_RDCLR: begin prpend <= 1'b1; prflag <= 1'b0; end
          default: ;
        endcase
      end
      // Flags only rise while the bus is quiet.
      if (~iop_any & ~kbflag & ~kb_empty) kbflag <= 1'b1;
      if (~iop_any & prpend & ~pr_full) begin
        prflag <= 1'b1;
        prpend <= 1'b0;
      end
    end
  end

  // PDP bus outputs: loaded on the IOP edge, held while it lasts, cleared after.
  always_ff @(posedge CLOCK) begin
    if (rst | ~iop_any) begin
      INPUTBUS <= '0;
      AC_CLEAR <= 1'b0;
      IO_SKIP  <= 1'b0;
    end else if (iop_act) begin
      if (iop_kb) begin
        case (fn)
          F_SKIP:  IO_SKIP  <= kbflag;
          F_CLR:   AC_CLEAR <= 1'b1;
          F_RD:    INPUTBUS <= {4'b0, kb_head};
          F_RDCLR: begin AC_CLEAR <= 1'b1; INPUTBUS <= {4'b0, kb_head}; end
          default: ;
        endcase
      end
      if (iop_pr) begin
        case (fn)
          F_SKIP:  IO_SKIP <= prflag;
          F_IE:    IO_SKIP <= INT_RQST;
          default: ;
        endcase
      end
    end
  end

  // ARM register read mux.
  always_comb begin
    armrdata = '0;
    case (armraddr)
      R_ID:    armrdata = {ID_MAGIC, ID_TYPE, VERSION};
      R_KB:    armrdata = {kbovf, 7'b0, 8'(kb_count), 8'b0, kb_head};
      R_PR:    armrdata = {~pr_empty, 7'b0, 8'(pr_count), 8'b0, pr_head};
      default: armrdata = {28'b0, lpbk, intenab, prflag, kbflag};
    endcase
  end

endmodule

// File: tb/tb_pdp8l_tty_buffered.sv
// Bench for pdp8l_tty_buffered: directed scenarios plus a randomized run
// checked against a transaction-level model built from queues and flags.
module tb_pdp8l_tty_buffered;

  localparam logic [5:0]  KBDEV  = 6'o03;
  localparam logic [5:0]  PRDEV  = 6'o04;
  localparam logic [31:0] ID_EXP = 32'h5454_1002;
  localparam logic [1:0]  A_ID = 2'd0, A_KB = 2'd1, A_PR = 2'd2, A_CTL = 2'd3;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        armwpulse = 1'b0;
  logic [1:0]  armraddr = 2'd0;
  logic [1:0]  armwaddr = 2'd0;
  logic [31:0] armwdata = 32'd0;
  logic [31:0] armrdata;
  logic [11:0] INPUTBUS;
  logic        AC_CLEAR, INT_RQST, IO_SKIP;
  logic [11:0] BAC = 12'd0;
  logic        BIOP1 = 1'b0, BIOP2 = 1'b0, BIOP4 = 1'b0;
  logic [11:0] BMB = 12'd0;
  logic        BUSINIT = 1'b0;

  always #5 CLOCK = ~CLOCK;

  pdp8l_tty_buffered dut (
    .CLOCK(CLOCK), .RESET(RESET), .armwpulse(armwpulse), .armraddr(armraddr),
    .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata),
    .INPUTBUS(INPUTBUS), .AC_CLEAR(AC_CLEAR), .INT_RQST(INT_RQST), .IO_SKIP(IO_SKIP),
    .BAC(BAC), .BIOP1(BIOP1), .BIOP2(BIOP2), .BIOP4(BIOP4), .BMB(BMB), .BUSINIT(BUSINIT)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [7:0] kbq[$];
  logic [7:0] prq[$];
  bit m_kbflag, m_prflag, m_prpend, m_kbovf, m_intenab, m_lpbk;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  function automatic void model_reset();
    kbq.delete();
    prq.delete();
    m_kbflag = 0; m_prflag = 0; m_prpend = 0;
    m_kbovf = 0; m_intenab = 0; m_lpbk = 0;
  endfunction

  // Quiet-bus consequences: loopback drains, flags rise.
  function automatic void model_settle();
    if (m_lpbk)
      while (prq.size() > 0 && kbq.size() < 16) kbq.push_back(prq.pop_front());
    if (!m_kbflag && kbq.size() > 0) m_kbflag = 1;
    if (m_prpend && prq.size() < 16) begin
      m_prflag = 1;
      m_prpend = 0;
    end
  endfunction

  function automatic logic [31:0] exp_reg(input logic [1:0] a);
    logic [7:0] kh, ph;
    kh = (kbq.size() > 0) ? kbq[0] : 8'h00;
    ph = (prq.size() > 0) ? prq[0] : 8'h00;
    case (a)
      2'd0:    return ID_EXP;
      2'd1:    return {m_kbovf, 7'b0, 8'(kbq.size()), 8'b0, kh};
      2'd2:    return {prq.size() > 0, 7'b0, 8'(prq.size()), 8'b0, ph};
      default: return {28'b0, m_lpbk, m_intenab, m_prflag, m_kbflag};
    endcase
  endfunction

  function automatic void model_iot(input bit pr, input logic [2:0] fn, input logic [11:0] ac,
                                    output logic [11:0] ib, output logic acc, output logic skp);
    logic [7:0] kh;
    kh  = (kbq.size() > 0) ? kbq[0] : 8'h00;
    ib  = 12'd0; acc = 1'b0; skp = 1'b0;
    if (!pr) begin
      case (fn)
        3'd1: skp = m_kbflag;
        3'd2: begin acc = 1'b1; m_kbflag = 0; if (kbq.size() > 0) void'(kbq.pop_front()); end
        3'd4: ib = {4'b0, kh};
        3'd5: m_intenab = ac[0];
        3'd6: begin
          acc = 1'b1; ib = {4'b0, kh}; m_kbflag = 0;
          if (kbq.size() > 0) void'(kbq.pop_front());
        end
        default: ;
      endcase
    end else begin
      case (fn)
        3'd1: skp = m_prflag;
        3'd2: m_prflag = 0;
        3'd4: begin if (prq.size() < 16) prq.push_back(ac[7:0]); m_prpend = 1; end
        3'd5: skp = m_intenab & (m_kbflag | m_prflag);
        3'd6: begin
          if (prq.size() < 16) prq.push_back(ac[7:0]);
          m_prpend = 1; m_prflag = 0;
        end
        default: ;
      endcase
    end
  endfunction

  task automatic arm_read(input logic [1:0] a, output logic [31:0] d);
    armraddr = a;
    #1;
    d = armrdata;
  endtask

  task automatic arm_write(input logic [1:0] a, input logic [31:0] d);
    armwaddr = a; armwdata = d; armwpulse = 1'b1;
    tick();
    armwpulse = 1'b0;
    case (a)
      2'd1: if (kbq.size() == 16) m_kbovf = 1; else kbq.push_back(d[7:0]);
      2'd2: if (d[31] && prq.size() > 0) void'(prq.pop_front());
      2'd3: begin
        if (d[0]) m_kbovf = 0;
        if (d[1]) m_prflag = 1;
`ifdef PDP8L_TTY_LOOPBACK_EN
        m_lpbk = d[2];
`endif
      end
      default: ;
    endcase
    repeat (m_lpbk ? 20 : 3) tick();
    model_settle();
  endtask

  // Runs one IOT; returns what the bus showed and what the model expects.
  task automatic do_iot(input bit pr, input logic [2:0] fn, input logic [11:0] ac,
                        output logic [11:0] ib, output logic acc, output logic skp,
                        output logic [31:0] ctl_during, output logic held, output logic cleared,
                        output logic [11:0] e_ib, output logic e_acc, output logic e_skp);
    model_iot(pr, fn, ac, e_ib, e_acc, e_skp);
    armraddr = A_CTL;
    BMB = {3'o6, (pr ? PRDEV : KBDEV), fn};
    BAC = ac;
    BIOP1 = (fn == 3'd1) || (fn == 3'd5);
    BIOP2 = (fn == 3'd2) || (fn == 3'd6);
    BIOP4 = (fn == 3'd4);
    tick();
    ib = INPUTBUS; acc = AC_CLEAR; skp = IO_SKIP; ctl_during = armrdata;
    tick();
    held = (INPUTBUS === ib) && (AC_CLEAR === acc) && (IO_SKIP === skp);
    BIOP1 = 1'b0; BIOP2 = 1'b0; BIOP4 = 1'b0;
    tick();
    cleared = (INPUTBUS === 12'd0) && (AC_CLEAR === 1'b0) && (IO_SKIP === 1'b0);
    repeat (m_lpbk ? 20 : 3) tick();
    model_settle();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    model_reset();
    tick();
    n_checks++;
    if (INPUTBUS !== 12'd0 || AC_CLEAR !== 1'b0 || IO_SKIP !== 1'b0 || INT_RQST !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bus: got ib=%o acc=%b skp=%b irq=%b required all 0",
               INPUTBUS, AC_CLEAR, IO_SKIP, INT_RQST);
    end
    arm_read(A_ID, d);
    n_checks++;
    if (d !== 32'h5454_1002) begin n_fail++; $display("FAIL reset_id: got %h required %h", d, 32'h5454_1002); end
    for (int a = 1; a < 4; a++) begin
      arm_read(a[1:0], d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL reset_r%0d: got %h required 0", a, d); end
    end
  endtask

  task automatic test_kb_read();
    logic [11:0] ib, eib; logic acc, skp, held, clr, eacc, eskp; logic [31:0] ctl, d;
    arm_write(A_KB, 32'h41);
    arm_write(A_KB, 32'h42);
    arm_read(A_CTL, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL kb_flag_up: got %h required 1", d); end
    do_iot(1'b0, 3'd6, 12'd0, ib, acc, skp, ctl, held, clr, eib, eacc, eskp);
    n_checks++;
    if (ib !== 12'o101 || acc !== 1'b1 || !held || !clr) begin
      n_fail++;
      $display("FAIL krb1: got ib=%o acc=%b held=%b clr=%b required 101 1 1 1", ib, acc, held, clr);
    end
    arm_read(A_CTL, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL kb_flag_reraise: got %h required 1", d); end
    arm_read(A_KB, d);
    n_checks++;
    if (d !== 32'h0001_0042) begin n_fail++; $display("FAIL kb_after_pop: got %h required 00010042", d); end
    do_iot(1'b0, 3'd6, 12'd0, ib, acc, skp, ctl, held, clr, eib, eacc, eskp);
    n_checks++;
    if (ib !== 12'o102 || acc !== 1'b1) begin
      n_fail++; $display("FAIL krb2: got ib=%o acc=%b required 102 1", ib, acc);
    end
    arm_read(A_CTL, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL kb_flag_down: got %h required 0", d); end
  endtask

  task automatic test_kb_overflow();
    logic [11:0] ib, eib; logic acc, skp, held, clr, eacc, eskp; logic [31:0] ctl, d;
    for (int i = 0; i < 17; i++) arm_write(A_KB, 32'h60 + i);
    arm_read(A_KB, d);
    n_checks++;
    if (d !== 32'h8010_0060) begin n_fail++; $display("FAIL kb_ovf_set: got %h required 80100060", d); end
    arm_write(A_CTL, 32'h1);
    arm_read(A_KB, d);
    n_checks++;
    if (d !== 32'h0010_0060) begin n_fail++; $display("FAIL kb_ovf_clr: got %h required 00100060", d); end
    for (int i = 0; i < 16; i++) begin
      do_iot(1'b0, 3'd6, 12'd0, ib, acc, skp, ctl, held, clr, eib, eacc, eskp);
      n_checks++;
      if (ib !== 12'h060 + 12'(i)) begin
        n_fail++; $display("FAIL kb_drain_%0d: got %h required %h", i, ib, 12'h060 + 12'(i));
      end
    end
    arm_read(A_KB, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL kb_drained: got %h required 0", d); end
  endtask

  task automatic test_printer();
    logic [11:0] ib, eib; logic acc, skp, held, clr, eacc, eskp; logic [31:0] ctl, d;
    do_iot(1'b1, 3'd6, 12'o215, ib, acc, skp, ctl, held, clr, eib, eacc, eskp);
    n_checks++;
    if (ctl[1] !== 1'b0 || ib !== 12'd0 || acc !== 1'b0) begin
      n_fail++; $display("FAIL tls_during: got prflag=%b ib=%o acc=%b required 0 0 0", ctl[1], ib, acc);
    end
    arm_read(A_CTL, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL tls_prflag: got %h required 2", d); end
    arm_read(A_PR, d);
    n_checks++;
    if (d !== 32'h8001_008D) begin n_fail++; $display("FAIL pr_head: got %h required 8001008d", d); end
    arm_write(A_PR, 32'h8000_0000);
    arm_read(A_PR, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL pr_pop: got %h required 0", d); end
    do_iot(1'b1, 3'd1, 12'd0, ib, acc, skp, ctl, held, clr, eib, eacc, eskp);
    n_checks++;
    if (skp !== 1'b1) begin n_fail++; $display("FAIL tsf_skip: got %b required 1", skp); end
    do_iot(1'b1, 3'd2, 12'd0, ib, acc, skp, ctl, held, clr, eib, eacc, eskp);
    arm_read(A_CTL, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL tcf: got %h required 0", d); end
  endtask

  task automatic test_interrupt();
    logic [11:0] ib, eib; logic acc, skp, held, clr, eacc, eskp; logic [31:0] ctl, d;
    do_iot(1'b0, 3'd5, 12'd1, ib, acc, skp, ctl, held, clr, eib, eacc, eskp);
    n_checks++;
    if (INT_RQST !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b required 0", INT_RQST); end
    arm_write(A_KB, 32'h99);
    n_checks++;
    if (INT_RQST !== 1'b1) begin n_fail++; $display("FAIL irq_kb: got %b required 1", INT_RQST); end
    do_iot(1'b1, 3'd5, 12'd0, ib, acc, skp, ctl, held, clr, eib, eacc, eskp);
    n_checks++;
    if (skp !== 1'b1 || !held || !clr) begin
      n_fail++; $display("FAIL tsk_skip: got skp=%b held=%b clr=%b required 1 1 1", skp, held, clr);
    end
    do_iot(1'b0, 3'd1, 12'd0, ib, acc, skp, ctl, held, clr, eib, eacc, eskp);
    n_checks++;
    if (skp !== 1'b1) begin n_fail++; $display("FAIL ksf_skip: got %b required 1", skp); end
    BUSINIT = 1'b1;
    tick();
    BUSINIT = 1'b0;
    model_reset();
    tick();
    n_checks++;
    if (INT_RQST !== 1'b0) begin n_fail++; $display("FAIL businit_irq: got %b required 0", INT_RQST); end
    arm_read(A_KB, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL businit_kb: got %h required 0", d); end
    arm_read(A_CTL, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL businit_ctl: got %h required 0", d); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] ib, eib; logic acc, skp, held, clr, eacc, eskp; logic [31:0] ctl, d;
    logic [11:0] ib_a, ib_b;
    arm_write(A_KB, 32'h21);
    BMB = 12'o6034; BIOP4 = 1'b1;
    armwaddr = A_KB; armwdata = 32'h33; armwpulse = 1'b1;
    tick();
    armwpulse = 1'b0;
    kbq.push_back(8'h33);
    ib_a = INPUTBUS;
    tick();
    ib_b = INPUTBUS;
    BIOP4 = 1'b0;
    repeat (3) tick();
    model_settle();
    n_checks++;
    if (ib_a !== 12'd0 || ib_b !== 12'd0) begin
      n_fail++; $display("FAIL prio_iop_ignored: got %o/%o required 0/0", ib_a, ib_b);
    end
    arm_read(A_KB, d);
    n_checks++;
    if (d !== 32'h0002_0021) begin n_fail++; $display("FAIL prio_write_taken: got %h required 00020021", d); end
    do_iot(1'b0, 3'd4, 12'd0, ib, acc, skp, ctl, held, clr, eib, eacc, eskp);
    n_checks++;
    if (ib !== 12'h021 || acc !== 1'b0) begin
      n_fail++; $display("FAIL krs: got ib=%h acc=%b required 021 0", ib, acc);
    end
    do_iot(1'b0, 3'd6, 12'd0, ib, acc, skp, ctl, held, clr, eib, eacc, eskp);
    do_iot(1'b0, 3'd6, 12'd0, ib, acc, skp, ctl, held, clr, eib, eacc, eskp);
    n_checks++;
    if (ib !== 12'h033) begin n_fail++; $display("FAIL prio_second_char: got %h required 033", ib); end
    do_iot(1'b0, 3'd6, 12'd0, ib, acc, skp, ctl, held, clr, eib, eacc, eskp);
    n_checks++;
    if (ib !== 12'd0 || acc !== 1'b1) begin
      n_fail++; $display("FAIL krb_empty: got ib=%h acc=%b required 0 1", ib, acc);
    end
  endtask

  task automatic test_loopback();
    logic [31:0] d;
`ifdef PDP8L_TTY_LOOPBACK_EN
    logic [11:0] ib, eib; logic acc, skp, held, clr, eacc, eskp; logic [31:0] ctl;
    arm_write(A_CTL, 32'h4);
    arm_read(A_CTL, d);
    n_checks++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL lpbk_rw: got %h required 4", d); end
    do_iot(1'b1, 3'd6, 12'h055, ib, acc, skp, ctl, held, clr, eib, eacc, eskp);
    arm_read(A_CTL, d);
    n_checks++;
    if (d[0] !== 1'b1) begin n_fail++; $display("FAIL lpbk_kbflag: got %b required 1", d[0]); end
    do_iot(1'b0, 3'd6, 12'd0, ib, acc, skp, ctl, held, clr, eib, eacc, eskp);
    n_checks++;
    if (ib !== 12'h055) begin n_fail++; $display("FAIL lpbk_char: got %h required 055", ib); end
    arm_write(A_CTL, 32'h0);
`else
    arm_write(A_CTL, 32'h4);
    arm_read(A_CTL, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL lpbk_absent: got %h required 0", d); end
`endif
  endtask

  task automatic test_random();
    logic [11:0] ib, eib; logic acc, skp, held, clr, eacc, eskp; logic [31:0] ctl, d;
    int r;
    logic [2:0] fn;
    logic [2:0] fns [5];
    fns[0] = 3'd1; fns[1] = 3'd2; fns[2] = 3'd4; fns[3] = 3'd5; fns[4] = 3'd6;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    model_reset();
    tick();
    for (int op = 0; op < 300; op++) begin
      r  = $urandom_range(0, 9);
      fn = fns[$urandom_range(0, 4)];
      if (r <= 3) arm_write(A_KB, 32'($urandom_range(0, 255)));
      else if (r == 4) arm_write(A_PR, {($urandom_range(0, 3) != 0), 31'd0});
      else if (r == 5) arm_write(A_CTL, 32'($urandom_range(0, 7)));
      else begin
        do_iot(r >= 8, fn, 12'($urandom_range(0, 4095)), ib, acc, skp, ctl, held, clr, eib, eacc, eskp);
        n_checks++;
        if (ib !== eib || acc !== eacc || skp !== eskp || !held || !clr) begin
          n_fail++;
          $display("FAIL rand_iot op%0d pr=%0d fn=%0d: got ib=%h acc=%b skp=%b held=%b clr=%b required ib=%h acc=%b skp=%b held=1 clr=1",
                   op, r >= 8, fn, ib, acc, skp, held, clr, eib, eacc, eskp);
        end
      end
      for (int a = 1; a < 4; a++) begin
        arm_read(a[1:0], d);
        n_checks++;
        if (d !== exp_reg(a[1:0])) begin
          n_fail++; $display("FAIL rand_r%0d op%0d: got %h required %h", a, op, d, exp_reg(a[1:0]));
        end
      end
      n_checks++;
      if (INT_RQST !== (m_intenab & (m_kbflag | m_prflag))) begin
        n_fail++; $display("FAIL rand_irq op%0d: got %b required %b", op, INT_RQST,
                           m_intenab & (m_kbflag | m_prflag));
      end
    end
  endtask

  initial begin
    test_reset();
    test_kb_read();
    test_kb_overflow();
    test_printer();
    test_interrupt();
    test_back_to_back();
    test_loopback();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
